// File: rtl/out_mem_drain.sv
// Drains the output memory in ascending address order, requantizes each bank's
// partial sum to DATA_WIDTH and streams SYS_COL-wide beats over valid/ready.

module out_mem_drain_lane #(
  parameter int PW = 32,
  parameter int DW = 16,
  parameter int SW = 5
) (
  input  logic [PW-1:0] psum,
  input  logic [SW-1:0] shamt,
  output logic [DW-1:0] q
);
  localparam logic signed [PW-1:0] MAXV = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [PW-1:0] shifted;

  always_comb begin
    shifted = $signed(psum) >>> shamt;
    if (shifted > MAXV)      q = MAXV[DW-1:0];
    else if (shifted < MINV) q = MINV[DW-1:0];
    else                     q = shifted[DW-1:0];
  end
endmodule

module out_mem_drain #(
  parameter  int SYS_COL    = 16,
  parameter  int DATA_WIDTH = 16,
  parameter  int ADDR_WIDTH = 16,
  localparam int PSUM_WIDTH = 2*DATA_WIDTH,
  localparam int SH_WIDTH   = $clog2(PSUM_WIDTH)
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  start,
  input  logic [DATA_WIDTH-1:0]                 num_row,
  input  logic [DATA_WIDTH-1:0]                 num_out,
  input  logic [SH_WIDTH-1:0]                   shamt,
  output logic [SYS_COL-1:0]                    rd_en,
  output logic [0:SYS_COL-1][ADDR_WIDTH-1:0]    rd_addr,
  input  logic [0:SYS_COL-1][PSUM_WIDTH-1:0]    rd_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [0:SYS_COL-1][DATA_WIDTH-1:0]    out_data,
  output logic                                  out_last,
  output logic                                  busy,
  output logic                                  done
);
  localparam int LG = $clog2(SYS_COL);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [2*DATA_WIDTH-1:0] MAX_TOT = (2*DATA_WIDTH)'(1) << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, READ, FLUSH, FIN} state_t;
  typedef logic [0:SYS_COL-1][DATA_WIDTH-1:0] beat_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       total_q, total_d, issued_q, issued_d;
  logic [SH_WIDTH-1:0] shamt_q, shamt_d;
  logic                inflight_q, inflight_d, infl_last_q, infl_last_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  beat_t               fifo_q [2];
  beat_t               fifo_d [2];
  logic [1:0]          fifo_last_q, fifo_last_d;

  logic [2*DATA_WIDTH-1:0] prod;
  logic [CW-1:0]           total_clamp;
  beat_t                   rq_data;
  logic                    push, pop, rd_go;
  logic [2:0]              occ;

  for (genvar k = 0; k < SYS_COL; k++) begin : g_lane
    out_mem_drain_lane #(.PW(PSUM_WIDTH), .DW(DATA_WIDTH), .SW(SH_WIDTH)) u_lane (
      .psum (rd_data[k]),
      .shamt(shamt_q),
      .q    (rq_data[k])
    );
  end

  assign prod        = (2*DATA_WIDTH)'(num_row) * (2*DATA_WIDTH)'(num_out >> LG);
  assign total_clamp = (prod > MAX_TOT) ? MAX_TOT[CW-1:0] : prod[CW-1:0];

  assign push = inflight_q;
  assign pop  = (cnt_q != 2'd0) && out_ready;
  // A slot freed by this cycle's pop may be refilled, which keeps 1 beat/cycle.
  assign occ   = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
  assign rd_go = (state_q == READ) && (occ < 3'd2);

  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    issued_d    = issued_q;
    shamt_d     = shamt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_d      = fifo_q;
    fifo_last_d = fifo_last_q;
    inflight_d  = rd_go;
    infl_last_d = rd_go && (issued_q == total_q - CW'(1));
    cnt_d       = cnt_q + 2'(push) - 2'(pop);

    if (push) begin
      fifo_d[wr_ptr_q]      = rq_data;
      fifo_last_d[wr_ptr_q] = infl_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    case (state_q)
      IDLE: if (start) begin
        total_d  = total_clamp;
        shamt_d  = shamt;
        issued_d = '0;
        state_d  = (total_clamp == '0) ? FIN : READ;
      end
      READ: if (rd_go) begin
        issued_d = issued_q + CW'(1);
        if (issued_q + CW'(1) == total_q) state_d = FLUSH;
      end
      FLUSH: if (!inflight_q && cnt_d == 2'd0) state_d = FIN;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      total_q     <= '0;
      issued_q    <= '0;
      shamt_q     <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      cnt_q       <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fifo_last_q <= '0;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      issued_q    <= issued_d;
      shamt_q     <= shamt_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_last_q <= fifo_last_d;
    end
  end

  // Payload storage needs no reset; visibility is gated by cnt_q.
  always_ff @(posedge clk) fifo_q <= fifo_d;

  assign rd_en     = {SYS_COL{rd_go}};
  assign rd_addr   = {SYS_COL{rd_go ? issued_q[ADDR_WIDTH-1:0] : {ADDR_WIDTH{1'b0}}}};
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = out_valid ? fifo_q[rd_ptr_q] : '0;
  assign out_last  = out_valid & fifo_last_q[rd_ptr_q];
  assign busy      = (state_q == READ) || (state_q == FLUSH);
  assign done      = (state_q == FIN);
endmodule

// File: tb/tb_out_mem_drain.sv
// Randomized bench for out_mem_drain: memory model, ready patterns and a
// reference queue of expected beats built from the requant rules.

module tb_out_mem_drain;
  localparam int SC = 16, DW = 16, AW = 16, PW = 32, SW = 5;
  typedef logic [0:SC-1][DW-1:0] beat_t;

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] num_row = '0, num_out = '0;
  logic [SW-1:0] shamt = '0;
  logic [SC-1:0] rd_en;
  logic [0:SC-1][AW-1:0] rd_addr;
  logic [0:SC-1][PW-1:0] rd_data;
  logic out_valid, out_last, busy, done;
  beat_t out_data;

  always #5 clk = ~clk;

  out_mem_drain #(.SYS_COL(SC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .num_row(num_row), .num_out(num_out),
    .shamt(shamt), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done));

  logic [PW-1:0] mem [0:63][0:SC-1];

  // 1-cycle latency memory; garbage when not read
  always @(posedge clk)
    for (int k = 0; k < SC; k++)
      rd_data[k] <= rd_en[k] ? mem[rd_addr[k][5:0]][k] : PW'($urandom);

  int n_vec = 0, n_err = 0;
  int cyc = 0, rcyc = 0, rmode = 0;
  int issued, accepted, beat, tot, fv, last_hs, done_neg, done_cnt;
  bit mon_on = 1'b0, prev_stall;
  logic [271:0] prev;
  beat_t exp_q[$];
  beat_t got_q[$];

  task automatic chk(input string tag, input logic [271:0] obs, input logic [271:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rq(input logic [PW-1:0] w, input int sh);
    longint v;
    v = longint'($signed(w)) >>> sh;
    if (v > 32767)  return 16'h7fff;
    if (v < -32768) return 16'h8000;
    return DW'(v);
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    rcyc++;
    case (rmode)
      0: out_ready = 1'b1;
      1: out_ready = (rcyc >= 6 && rcyc < 11) ? 1'b0 : (rcyc % 2 == 0);
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  always @(negedge clk) if (mon_on) begin
    if (|rd_en) begin
      logic [AW-1:0] ia;
      logic [0:SC-1][AW-1:0] ea;
      ia = AW'(issued);
      ea = {SC{ia}};
      chk("rd_en_all", rd_en, {SC{1'b1}});
      chk("rd_addr", rd_addr, ea);
      chk("no_overflow", (issued - accepted - ((out_valid && out_ready) ? 1 : 0)) <= 1, 1);
      issued++;
    end
    if (out_valid) begin
      if (fv < 0) fv = cyc;
      if (prev_stall) chk("stall_hold", {out_data, out_last}, prev);
      if (beat < exp_q.size()) begin
        chk("data", out_data, exp_q[beat]);
        chk("last", out_last, beat == tot - 1);
      end else chk("extra_beat", 1, 0);
      if (out_ready) begin
        got_q.push_back(out_data);
        accepted++; beat++; last_hs = cyc;
      end
    end
    prev_stall = out_valid && !out_ready;
    prev = {out_data, out_last};
    if (done) begin done_cnt++; done_neg = cyc; end
  end

  task automatic mon_clear(input int t);
    issued = 0; accepted = 0; beat = 0; tot = t; fv = -1; last_hs = -1;
    done_neg = -1; done_cnt = 0; prev_stall = 1'b0; got_q.delete();
  endtask

  task automatic build_exp(input int t, input int sh);
    beat_t e;
    exp_q.delete();
    for (int i = 0; i < t; i++) begin
      for (int k = 0; k < SC; k++) e[k] = rq(mem[i][k], sh);
      exp_q.push_back(e);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {rd_en, rd_addr, out_valid, out_data, out_last, busy, done}, '0);
  endtask

  task automatic run_drain(input int nr, input int no, input int sh, input int rm, input int re_nr);
    int t, ts;
    t = nr * (no / SC);
    build_exp(t, sh);
    mon_clear(t);
    rmode = rm; rcyc = 0;
    @(posedge clk); #1;
    start = 1'b1; num_row = DW'(nr); num_out = DW'(no); shamt = SW'(sh);
    mon_on = 1'b1;
    ts = cyc + 1;
    @(posedge clk); #1 start = 1'b0;
    if (re_nr >= 0) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1; num_row = DW'(re_nr); shamt = SW'(sh ^ 3);
      @(posedge clk); #1 start = 1'b0;
    end
    for (int b = 0; b < 3000 && done_cnt == 0; b++) @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("done_once", done_cnt, 1);
    chk("beats", beat, t);
    chk("reads", issued, t);
    chk("busy_end", busy, 0);
    if (t == 0) begin
      chk("zero_done_lat", done_neg - ts, 0);
      chk("zero_no_valid", fv, -1);
    end else begin
      chk("first_valid_lat", fv - ts, 2);
      chk("done_after_last", done_neg - last_hs, 1);
      if (rm == 0) chk("back_to_back", last_hs - fv, t - 1);
    end
    mon_on = 1'b0;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++)
      for (int k = 0; k < SC; k++) mem[i][k] = PW'($urandom);
  endtask

  initial begin
    for (int i = 0; i < 64; i++)
      for (int k = 0; k < SC; k++) mem[i][k] = PW'(i * 16 + k);
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) chk_idle("reset_outputs");
    @(posedge clk); #1 rstn = 1'b1;

    // plain drain, ready high
    run_drain(4, 32, 0, 0, -1);
    // toggling ready with a 5-cycle stall
    run_drain(4, 32, 0, 1, -1);

    // shift/saturate corners
    fill_rand();
    mem[0][0] = 32'h0001_8000;
    run_drain(1, 16, 4, 0, -1);
    chk("rq_shift4", got_q[0][0], 16'h1800);
    mem[0][0] = 32'h7FFF_FFFF;
    mem[0][1] = 32'hFFFF_0000;
    run_drain(1, 16, 0, 2, -1);
    chk("rq_sat_pos", got_q[0][0], 16'h7FFF);
    chk("rq_sat_neg", got_q[0][1], 16'h8000);

    // empty drains
    run_drain(0, 32, 0, 0, -1);
    run_drain(3, 8, 0, 0, -1);

    // reset mid-drain with a beat pending
    fill_rand();
    build_exp(32, 2);
    mon_clear(32);
    rmode = 1; rcyc = 0;
    @(posedge clk); #1 start = 1'b1; num_row = 16'd8; num_out = 16'd64; shamt = 5'd2;
    @(posedge clk); #1 start = 1'b0;
    for (int b = 0; b < 200 && !(out_valid && !out_ready && rcyc > 12); b++) @(posedge clk);
    #2;
    chk("beat_pending", out_valid, 1);
    rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk) chk_idle("midreset_outputs");
    run_drain(8, 64, 2, 2, -1);

    // start while busy is ignored
    run_drain(6, 32, 1, 2, 1);

    for (int r = 0; r < 6; r++) begin
      fill_rand();
      run_drain($urandom_range(0, 6), 16 * $urandom_range(0, 4), $urandom_range(0, 31),
                $urandom_range(0, 2), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
